// File: rtl/pistormx_pkg.sv
// Shared PistormX types: queued bus-operation record and Pi register map.
// Pure declarations, no logic.
package pistormx_pkg;

    localparam int TXN_AW = 23;
    localparam int TXN_DW = 16;

    typedef struct packed {
        logic [TXN_AW-1:0] a;
        logic              a0;
        logic              sz;
        logic              rw;
        logic [TXN_DW-1:0] wdata;
    } txn_t;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_ADDR_LO = 2'd1;
    localparam logic [1:0] REG_ADDR_HI = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

endpackage

// File: rtl/pistormx_fifo_mem.sv
// Transaction storage array: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none here, the owner guarantees writes only target free slots.
module pistormx_fifo_mem
    import pistormx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(txn_t),
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic             M68K_CLK,
    input  logic             we,
    input  logic [IW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge M68K_CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pistormx_txn_queue.sv
// DEPTH-entry FIFO of 68K bus operations between the Pi front-end and the bus-cycle engine.
// Latency: push visible on op_valid next cycle when idle; op_done updates pi_rdata/pi_busy next cycle.
// Backpressure: pushes while full are dropped and flagged on pi_ovf; PISTORMX_POSTED_WRITE_EN frees pi_busy on writes.
module pistormx_txn_queue
    import pistormx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 23,
    parameter int DW    = 16,
    localparam int IW   = $clog2(DEPTH),
    localparam int PW   = IW + 1
) (
    input  logic          M68K_CLK,
    input  logic          RESET_n,
    input  logic          pi_push,
    input  logic [AW-1:0] pi_addr,
    input  logic          pi_a0,
    input  logic          pi_sz,
    input  logic          pi_rw,
    input  logic [DW-1:0] pi_wdata,
    input  logic          pi_ovf_clr,
    output logic [DW-1:0] pi_rdata,
    output logic          pi_busy,
    output logic          pi_full,
    output logic          pi_ovf,
    output logic [PW-1:0] pi_level,
    output logic          op_valid,
    output logic [AW-1:0] op_a,
    output logic          op_a0,
    output logic          op_sz,
    output logic          op_rw,
    output logic [DW-1:0] op_wdata,
    input  logic          op_ready,
    input  logic          op_done,
    input  logic [DW-1:0] op_rdata
);

    localparam int TW = AW + DW + 3;

    logic [PW-1:0] wp, rp;
    logic          inflight, inflight_rd;
    logic          empty, full, pop, push_ok, drop, rd_done;
    logic [TW-1:0] head;

    assign empty    = (wp == rp);
    assign full     = (wp[PW-1] != rp[PW-1]) && (wp[IW-1:0] == rp[IW-1:0]);
    assign op_valid = !empty && !inflight;
    assign pop      = op_valid && op_ready;
    // A pop in the same cycle frees the slot the full-queue push writes into.
    assign push_ok  = pi_push && (!full || pop);
    assign drop     = pi_push && full && !pop;
    assign rd_done  = op_done && inflight && inflight_rd;

    assign pi_full  = full;
    assign pi_level = wp - rp;

    pistormx_fifo_mem #(.DEPTH(DEPTH), .WIDTH(TW)) u_mem (
        .M68K_CLK (M68K_CLK),
        .we       (push_ok),
        .waddr    (wp[IW-1:0]),
        .wdata    ({pi_addr, pi_a0, pi_sz, pi_rw, pi_wdata}),
        .raddr    (rp[IW-1:0]),
        .rdata    (head)
    );

    assign {op_a, op_a0, op_sz, op_rw, op_wdata} = head;

    always_ff @(posedge M68K_CLK) begin
        if (!RESET_n) begin
            wp          <= '0;
            rp          <= '0;
            inflight    <= 1'b0;
            inflight_rd <= 1'b0;
            pi_ovf      <= 1'b0;
            pi_rdata    <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop) begin
                rp          <= rp + 1'b1;
                inflight    <= 1'b1;
                inflight_rd <= op_rw;
            end else if (op_done && inflight) begin
                inflight <= 1'b0;
            end
            if (rd_done) pi_rdata <= op_rdata;
            if (drop) pi_ovf <= 1'b1;
            else if (pi_ovf_clr) pi_ovf <= 1'b0;
        end
    end

`ifdef PISTORMX_POSTED_WRITE_EN
    // Reads still queued plus the read in flight; up to DEPTH+1.
    logic [PW:0] rd_cnt;
    logic        rd_inc;

    assign rd_inc = push_ok && pi_rw;

    always_ff @(posedge M68K_CLK) begin
        if (!RESET_n) begin
            rd_cnt <= '0;
        end else if (rd_inc && !rd_done) begin
            rd_cnt <= rd_cnt + 1'b1;
        end else if (rd_done && !rd_inc) begin
            rd_cnt <= rd_cnt - 1'b1;
        end
    end

    assign pi_busy = (rd_cnt != '0) || full;
`else
    assign pi_busy = !empty || inflight;
`endif

endmodule

// File: tb/tb_pistormx_txn_queue.sv
// Directed self-checking bench for pistormx_txn_queue.
module tb_pistormx_txn_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 23;
    localparam int DW    = 16;
    localparam int PW    = $clog2(DEPTH) + 1;

`ifdef PISTORMX_POSTED_WRITE_EN
    localparam logic WR_BUSY = 1'b0;
`else
    localparam logic WR_BUSY = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          RESET_n = 1'b0;
    logic          pi_push = 1'b0;
    logic [AW-1:0] pi_addr = '0;
    logic          pi_a0 = 1'b0;
    logic          pi_sz = 1'b0;
    logic          pi_rw = 1'b0;
    logic [DW-1:0] pi_wdata = '0;
    logic          pi_ovf_clr = 1'b0;
    logic [DW-1:0] pi_rdata;
    logic          pi_busy, pi_full, pi_ovf;
    logic [PW-1:0] pi_level;
    logic          op_valid;
    logic [AW-1:0] op_a;
    logic          op_a0, op_sz, op_rw;
    logic [DW-1:0] op_wdata;
    logic          op_ready = 1'b0;
    logic          op_done = 1'b0;
    logic [DW-1:0] op_rdata = '0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pistormx_txn_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .M68K_CLK   (clk),
        .RESET_n    (RESET_n),
        .pi_push    (pi_push),
        .pi_addr    (pi_addr),
        .pi_a0      (pi_a0),
        .pi_sz      (pi_sz),
        .pi_rw      (pi_rw),
        .pi_wdata   (pi_wdata),
        .pi_ovf_clr (pi_ovf_clr),
        .pi_rdata   (pi_rdata),
        .pi_busy    (pi_busy),
        .pi_full    (pi_full),
        .pi_ovf     (pi_ovf),
        .pi_level   (pi_level),
        .op_valid   (op_valid),
        .op_a       (op_a),
        .op_a0      (op_a0),
        .op_sz      (op_sz),
        .op_rw      (op_rw),
        .op_wdata   (op_wdata),
        .op_ready   (op_ready),
        .op_done    (op_done),
        .op_rdata   (op_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic a0, input logic sz,
                        input logic rw, input logic [DW-1:0] d);
        pi_push  = 1'b1;
        pi_addr  = a;
        pi_a0    = a0;
        pi_sz    = sz;
        pi_rw    = rw;
        pi_wdata = d;
        cyc();
        pi_push  = 1'b0;
    endtask

    task automatic finish_op(input logic [DW-1:0] rd);
        cyc(3);
        op_done  = 1'b1;
        op_rdata = rd;
        cyc();
        op_done  = 1'b0;
        op_rdata = '0;
    endtask

    // Bus-engine model: wait for the head, check it, accept, complete 4 cycles later.
    task automatic serve(input string tag, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                         input logic erw, input logic [DW-1:0] rd);
        int t = 0;
        while (!op_valid && t < 50) begin
            cyc();
            t++;
        end
        if (!op_valid) begin
            chk({tag, "_timeout"}, {31'b0, op_valid}, 32'd1);
            return;
        end
        chk({tag, "_a"}, {9'b0, op_a}, {9'b0, ea});
        chk({tag, "_wdata"}, {16'b0, op_wdata}, {16'b0, ed});
        chk({tag, "_rw"}, {31'b0, op_rw}, {31'b0, erw});
        op_ready = 1'b1;
        cyc();
        op_ready = 1'b0;
        chk({tag, "_valid_inflight"}, {31'b0, op_valid}, 32'd0);
        finish_op(rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(2);
        RESET_n = 1'b1;
        chk("rst_valid", {31'b0, op_valid}, 0);
        chk("rst_busy", {31'b0, pi_busy}, 0);
        chk("rst_full", {31'b0, pi_full}, 0);
        chk("rst_level", {29'b0, pi_level}, 0);
        chk("rst_ovf", {31'b0, pi_ovf}, 0);
        chk("rst_rdata", {16'b0, pi_rdata}, 0);

        // Three writes issue in order
        push(23'h000100, 1'b0, 1'b0, 1'b0, 16'hAAAA);
        chk("t1_valid_n1", {31'b0, op_valid}, 1);
        chk("t1_level1", {29'b0, pi_level}, 1);
        push(23'h000102, 1'b0, 1'b0, 1'b0, 16'h5555);
        push(23'h000104, 1'b0, 1'b0, 1'b0, 16'h1234);
        chk("t1_level3", {29'b0, pi_level}, 3);
        chk("t1_busy_q", {31'b0, pi_busy}, {31'b0, WR_BUSY});
        serve("t1_op0", 23'h000100, 16'hAAAA, 1'b0, 16'h0);
        chk("t1_busy_d0", {31'b0, pi_busy}, {31'b0, WR_BUSY});
        serve("t1_op1", 23'h000102, 16'h5555, 1'b0, 16'h0);
        serve("t1_op2", 23'h000104, 16'h1234, 1'b0, 16'h0);
        chk("t1_busy_end", {31'b0, pi_busy}, 0);
        chk("t1_valid_end", {31'b0, op_valid}, 0);

        // Full queue and overflow
        for (int i = 0; i < 4; i++) push(23'h000200 + 23'(i), 1'b0, 1'b0, 1'b0, 16'h2000 + 16'(i));
        chk("t2_full", {31'b0, pi_full}, 1);
        chk("t2_level", {29'b0, pi_level}, 4);
        chk("t2_busy_full", {31'b0, pi_busy}, 1);
        chk("t2_ovf_pre", {31'b0, pi_ovf}, 0);
        push(23'h0002FF, 1'b0, 1'b0, 1'b0, 16'hDEAD);
        chk("t2_ovf", {31'b0, pi_ovf}, 1);
        chk("t2_level_drop", {29'b0, pi_level}, 4);
        pi_ovf_clr = 1'b1;
        cyc();
        pi_ovf_clr = 1'b0;
        chk("t2_ovf_clr", {31'b0, pi_ovf}, 0);
        pi_ovf_clr = 1'b1;
        push(23'h0002FE, 1'b0, 1'b0, 1'b0, 16'hDEAD);
        pi_ovf_clr = 1'b0;
        chk("t2_ovf_setwins", {31'b0, pi_ovf}, 1);
        pi_ovf_clr = 1'b1;
        cyc();
        pi_ovf_clr = 1'b0;
        for (int i = 0; i < 4; i++) serve("t2_drain", 23'h000200 + 23'(i), 16'h2000 + 16'(i), 1'b0, 16'h0);
        cyc();
        chk("t2_valid_end", {31'b0, op_valid}, 0);
        chk("t2_level_end", {29'b0, pi_level}, 0);

        // Read serialised behind a write
        push(23'h000300, 1'b0, 1'b0, 1'b0, 16'h0F0F);
        push(23'h5FF000, 1'b1, 1'b1, 1'b1, 16'h0000);
        chk("t3_busy_rd", {31'b0, pi_busy}, 1);
        serve("t3_w", 23'h000300, 16'h0F0F, 1'b0, 16'h0);
        chk("t3_busy_mid", {31'b0, pi_busy}, 1);
        chk("t3_rd_valid", {31'b0, op_valid}, 1);
        chk("t3_rd_a0", {31'b0, op_a0}, 1);
        chk("t3_rd_sz", {31'b0, op_sz}, 1);
        serve("t3_r", 23'h5FF000, 16'h0000, 1'b1, 16'h00C5);
        chk("t3_rdata", {16'b0, pi_rdata}, 32'h00C5);
        chk("t3_busy_end", {31'b0, pi_busy}, 0);

        // Push and accept together on a full queue
        for (int i = 0; i < 4; i++) push(23'h000400 + 23'(i), 1'b0, 1'b0, 1'b0, 16'h4000 + 16'(i));
        chk("t4_head", {9'b0, op_a}, 32'h000400);
        op_ready = 1'b1;
        push(23'h0004FF, 1'b0, 1'b0, 1'b0, 16'hBEEF);
        op_ready = 1'b0;
        chk("t4_level", {29'b0, pi_level}, 4);
        chk("t4_full", {31'b0, pi_full}, 1);
        chk("t4_ovf", {31'b0, pi_ovf}, 0);
        finish_op(16'h0);
        for (int i = 1; i < 4; i++) serve("t4_drain", 23'h000400 + 23'(i), 16'h4000 + 16'(i), 1'b0, 16'h0);
        serve("t4_last", 23'h0004FF, 16'hBEEF, 1'b0, 16'h0);

        // Pointer wrap across three fill/drain rounds
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++)
                push(23'h000500 + 23'(k * 4 + i), 1'b0, 1'b0, 1'b0, 16'h6000 + 16'(k * 16 + i));
            chk("t5_full", {31'b0, pi_full}, 1);
            for (int i = 0; i < 4; i++)
                serve("t5_drain", 23'h000500 + 23'(k * 4 + i), 16'h6000 + 16'(k * 16 + i), 1'b0, 16'h0);
        end
        cyc();
        chk("t5_valid_end", {31'b0, op_valid}, 0);
        chk("t5_level_end", {29'b0, pi_level}, 0);

        // Reset with a read in flight and two writes queued
        push(23'h000700, 1'b0, 1'b0, 1'b1, 16'h0000);
        push(23'h000701, 1'b0, 1'b0, 1'b0, 16'h7001);
        push(23'h000702, 1'b0, 1'b0, 1'b0, 16'h7002);
        op_ready = 1'b1;
        cyc();
        op_ready = 1'b0;
        chk("t6_level_pre", {29'b0, pi_level}, 2);
        chk("t6_busy_pre", {31'b0, pi_busy}, 1);
        RESET_n = 1'b0;
        cyc();
        RESET_n = 1'b1;
        op_done  = 1'b1;
        op_rdata = 16'hDEAD;
        cyc();
        op_done  = 1'b0;
        op_rdata = '0;
        cyc();
        chk("t6_valid", {31'b0, op_valid}, 0);
        chk("t6_level", {29'b0, pi_level}, 0);
        chk("t6_busy", {31'b0, pi_busy}, 0);
        chk("t6_rdata", {16'b0, pi_rdata}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pistormx_txn_queue.md
# pistormx_txn_queue

Parametrised transaction queue between the Pi register front-end and the 68K bus-cycle engine in PistormX. It replaces the single-entry write buffer with a DEPTH-entry FIFO of complete bus operations (address, byte select, size, direction, write data). Writes can be posted, so the Pi continues while earlier cycles drain. Reads are serialised behind all queued writes, and their data is returned to the Pi read-data register.

## Interface
Parameters:
- DEPTH, 4: queue entries. Must be a power of 2 and at least 2.
- AW, 23: address width, M68K_A[23:1].
- DW, 16: data width.

Ports:
- M68K_CLK  in  1  sole clock (c7m). All logic is on the rising edge.
- RESET_n  in  1  synchronous, active-low reset.
- pi_push  in  1  one-cycle strobe that enqueues the operation on the pi_* fields. It is already synchronised to M68K_CLK.
- pi_addr  in  AW  word address.
- pi_a0  in  1  byte lane select: 1 = LDS, 0 = UDS.
- pi_sz  in  1  1 = byte, 0 = word.
- pi_rw  in  1  1 = read, 0 = write.
- pi_wdata  in  DW  write data.
- pi_ovf_clr  in  1  clears pi_ovf.
- pi_rdata  out  DW  data from the most recent completed read.
- pi_busy  out  1  drives PI_TXN_IN_PROGRESS.
- pi_full  out  1  queue full.
- pi_ovf  out  1  sticky flag: a push was dropped.
- pi_level  out  $clog2(DEPTH)+1  number of queued entries, excluding the in-flight entry.
- op_valid  out  1  the head entry is presented to the bus engine.
- op_a / op_a0 / op_sz / op_rw / op_wdata  out  AW/1/1/1/DW  head entry fields.
- op_ready  in  1  bus engine accepts the head entry (entering S2).
- op_done  in  1  one-cycle pulse when the bus cycle completes (S7).
- op_rdata  in  DW  read data, valid together with op_done.

## Operation
- Storage is a circular buffer with write pointer wp and read pointer rp, each $clog2(DEPTH)+1 bits. The extra MSB distinguishes full from empty.
  - empty = (wp == rp).
  - full = MSBs differ and the low bits are equal.
  - Pointers wrap modulo 2·DEPTH.
- Push rules:
  - pi_push while not full stores the fields and increments wp.
  - pi_push while full drops the operation, sets pi_ovf, and leaves the queue unchanged.
- Issue:
  - op_valid = !empty && !inflight. The bus engine runs one cycle at a time.
  - op_valid && op_ready pops the entry, increments rp, sets inflight, and latches the popped rw into inflight_rd.
- Completion:
  - op_done while inflight clears inflight.
  - If inflight_rd is set, op_rdata is also captured into pi_rdata.
  - op_done without inflight is ignored.
- Read counting: rd_cnt counts the reads still queued plus the read in flight.
  - A pushed read increments rd_cnt.
  - A read op_done decrements it.
  - A simultaneous increment and decrement leaves it unchanged.
- Ordering is strict FIFO. A read never overtakes a queued write.
- pi_ovf_clr clears pi_ovf. If pi_ovf_clr coincides with a dropped push, set wins.
- Reset values (RESET_n low at a clock edge):
  - wp, rp, inflight, inflight_rd, rd_cnt, pi_ovf all 0.
  - pi_rdata = 0.
  - op_valid = 0, pi_busy = 0, pi_full = 0, pi_level = 0.
- Reset mid-operation drops all queued and in-flight entries. A later op_done is ignored because inflight = 0.

## Timing
- Push in cycle N: pi_level and pi_full update at N+1. If the queue was empty and idle, op_valid rises at N+1.
- Accept in cycle N: op_valid falls at N+1 and stays low until the op_done edge. Head fields are stable while op_valid is high.
- op_done in cycle N: pi_rdata and pi_busy update at N+1. The next op_valid can be asserted at N+1, giving no idle cycle between bus operations.
- Simultaneous push and pop in the same cycle: pi_level is unchanged. This is legal when full, because the pop frees the slot first.
- Push of a write while full in the same cycle as a pop: the push is accepted.

## Configuration
- PISTORMX_POSTED_WRITE_EN defined:
  - pi_busy = (rd_cnt != 0) || full.
  - Writes are acknowledged as soon as they are queued.
- PISTORMX_POSTED_WRITE_EN undefined:
  - pi_busy = !empty || inflight.
  - Every operation holds the Pi until its bus cycle completes, matching the legacy single-buffer behaviour.
  - The queue logic itself is unchanged.

## Structure
- Package pistormx_pkg holds:
  - The txn_t packed struct: a, a0, sz, rw, wdata.
  - Localparams REG_DATA, REG_ADDR_LO, REG_ADDR_HI, REG_STATUS, shared with the register front-end.
- One sub-module, pistormx_fifo_mem: a DEPTH×$bits(txn_t) register array with one write port and an asynchronous read port.
- Pointer, flag and counter logic stays in pistormx_txn_queue.

## Test plan
- Reset, then push 3 writes (0x000100/0xAAAA, 0x000102/0x5555, 0x000104/0x1234) with op_ready held high and op_done 4 cycles after each accept → ops issue in order. With POSTED_WRITE_EN, pi_busy stays 0; without it, pi_busy stays 1 until the third op_done.
- Push 4 writes with op_ready = 0, then a 5th push → pi_full = 1, pi_level = 4, 5th push dropped, pi_ovf = 1. pi_ovf_clr → pi_ovf = 0 next cycle.
- Push write W, then read R at 0xBFE001 with pi_sz = 1, pi_a0 = 1 → R issues only after W's op_done. op_done for R with op_rdata = 0x00C5 → pi_rdata = 0x00C5 and pi_busy falls the next cycle.
- Full queue with a simultaneous push and accept → pi_level stays 4, no overflow, and the new entry later issues last.
- Fill the queue and drain it 3 times (12 ops) → the pointer wrap preserves order and data. At the end, empty, op_valid = 0, pi_level = 0.
- Assert RESET_n low while an op is in flight and 2 entries are queued, then release and pulse op_done → op_valid = 0, pi_level = 0, pi_busy = 0, and pi_rdata remains 0.
